rca_arbiter: RTL and testbench



---
 rtl/rca_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rca_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rca_arbiter.sv
// rca_arbiter: round-robin sharing of one ripple-carry adder between two requesters.
// Operands are held on the adder for SETTLE_CYC cycles, then the sum is returned on a tagged response channel.

module decomposed_rca #(
    parameter int NBIT = 8
) (
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    output logic [NBIT-1:0] s
);

    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        fa_sum = x ^ y ^ ci;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        fa_carry = (x & y) | (x & ci) | (y & ci);
    endfunction

    logic [NBIT-1:0] carry_s;

    assign carry_s[0] = 1'b0;

    // The last stage's carry-out is dropped; overflow is derived from the sum in the sequencer.
    for (genvar i = 0; i < NBIT; i++) begin : g_bit
        assign s[i] = fa_sum(a[i], b[i], carry_s[i]);
        if (i < NBIT - 1) begin : g_carry
            assign carry_s[i+1] = fa_carry(a[i], b[i], carry_s[i]);
        end
    end

endmodule

module rca_arbiter #(
    parameter int NBIT       = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    input  logic [NBIT-1:0] req0_a,
    input  logic [NBIT-1:0] req0_b,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [NBIT-1:0] req1_a,
    input  logic [NBIT-1:0] req1_b,
    output logic            req1_ready,
    output logic            rsp_valid,
    output logic            rsp_id,
    output logic [NBIT-1:0] rsp_sum,
    output logic            rsp_ovf,
    input  logic            rsp_ready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
        $error("rca_arbiter: SETTLE_CYC must lie in 1..15");
    end

    logic [1:0]      state_r;
    logic [3:0]      cnt_r;
    logic [NBIT-1:0] op_a_r;
    logic [NBIT-1:0] op_b_r;
    logic            cur_id_r;
    logic            last_grant_r;
    logic            rsp_valid_r;
    logic            rsp_id_r;
    logic [NBIT-1:0] rsp_sum_r;
    logic            rsp_ovf_r;

    logic            idle_s;
    logic            grant_s;
    logic            accept_s;
    logic [NBIT-1:0] sum_s;

    decomposed_rca #(.NBIT(NBIT)) u_rca (
        .a (op_a_r),
        .b (op_b_r),
        .s (sum_s)
    );

    assign idle_s     = (state_r == ST_IDLE);
    assign req0_ready = idle_s && (grant_s == 1'b0);
    assign req1_ready = idle_s && (grant_s == 1'b1);
    assign accept_s   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_sum    = rsp_sum_r;
    assign rsp_ovf    = rsp_ovf_r;

    // Grant selection: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Sequencer: accept operands, wait out the settle window, then hold the response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            op_a_r       <= '0;
            op_b_r       <= '0;
            cur_id_r     <= 1'b0;
            last_grant_r <= 1'b1;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_sum_r    <= '0;
            rsp_ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_a_r       <= grant_s ? req1_a : req0_a;
                        op_b_r       <= grant_s ? req1_b : req0_b;
                        cur_id_r     <= grant_s;
                        last_grant_r <= grant_s;
                        cnt_r        <= CNT_LOAD;
                        state_r      <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    if (cnt_r == 4'd0) begin
                        rsp_sum_r   <= sum_s;
                        // A wrapped unsigned sum is always smaller than either operand.
                        rsp_ovf_r   <= (sum_s < op_a_r);
                        rsp_id_r    <= cur_id_r;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_arbiter.sv
// Scoreboard bench for rca_arbiter: directed vectors push expected responses, a monitor pops and compares.
// A second instance built with SETTLE_CYC=1 covers the shortest settle window.
module tb_rca_arbiter;

    typedef struct packed {
        logic       id;
        logic [7:0] sum;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       r0v = 1'b0, r1v = 1'b0;
    logic [7:0] r0a = 8'd0, r0b = 8'd0, r1a = 8'd0, r1b = 8'd0;
    logic       req0_ready, req1_ready;
    logic       rsp_valid, rsp_id, rsp_ovf;
    logic [7:0] rsp_sum;
    logic       rsp_ready = 1'b1;

    logic       s1_r0v = 1'b0;
    logic [7:0] s1_r0a = 8'd0, s1_r0b = 8'd0;
    logic       s1_req0_ready, s1_req1_ready;
    logic       s1_rsp_valid, s1_rsp_id, s1_rsp_ovf;
    logic [7:0] s1_rsp_sum;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   rise_q[$];

    rca_arbiter #(.NBIT(8), .SETTLE_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_a(r0a), .req0_b(r0b), .req0_ready(req0_ready),
        .req1_valid(r1v), .req1_a(r1a), .req1_b(r1b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf),
        .rsp_ready(rsp_ready)
    );

    rca_arbiter #(.NBIT(8), .SETTLE_CYC(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s1_r0v), .req0_a(s1_r0a), .req0_b(s1_r0b), .req0_ready(s1_req0_ready),
        .req1_valid(1'b0), .req1_a(8'd0), .req1_b(8'd0), .req1_ready(s1_req1_ready),
        .rsp_valid(s1_rsp_valid), .rsp_id(s1_rsp_id), .rsp_sum(s1_rsp_sum), .rsp_ovf(s1_rsp_ovf),
        .rsp_ready(1'b1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: pop on each newly presented response, check latency, hold stability and ready gating.
    int   acc_edge = 0;
    logic prev_valid = 1'b0, prev_hs = 1'b0;
    exp_t held;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if ((r0v && req0_ready) || (r1v && req1_ready)) acc_edge = cyc + 1;
            if (rsp_valid && (!prev_valid || prev_hs)) begin
                rise_q.push_back(cyc);
                chk("rsp_latency", cyc, acc_edge + 2);
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", int'(rsp_id), int'(e.id));
                    chk("rsp_sum", int'(rsp_sum), int'(e.sum));
                    chk("rsp_ovf", int'(rsp_ovf), int'(e.ovf));
                end
                held = '{id: rsp_id, sum: rsp_sum, ovf: rsp_ovf};
            end else if (rsp_valid) begin
                chk("hold_stable", int'({rsp_id, rsp_sum, rsp_ovf}), int'(held));
            end
            if (rsp_valid) chk("resp_readys_zero", int'({req0_ready, req1_ready}), 0);
            prev_valid = rsp_valid;
            prev_hs    = rsp_valid && rsp_ready;
        end
    end

    // Called at a negedge; returns at a negedge after the n-th accept edge.
    task automatic wait_accepts(input int n, output logic last_id);
        int got = 0;
        last_id = 1'b0;
        for (int t = 0; t < 200 && got < n; t++) begin
            #1;
            if (r0v && req0_ready) begin
                got++;
                last_id = 1'b0;
            end else if (r1v && req1_ready) begin
                got++;
                last_id = 1'b1;
            end
            @(negedge clk);
        end
        chk("accept_count", got, n);
    endtask

    task automatic send(input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] esum, input logic eovf);
        logic lid;
        exp_q.push_back('{id: id, sum: esum, ovf: eovf});
        if (id) begin r1v = 1'b1; r1a = a; r1b = b; end
        else    begin r0v = 1'b1; r0a = a; r0b = b; end
        wait_accepts(1, lid);
        chk("grant_id", int'(lid), int'(id));
        r0v = 1'b0;
        r1v = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && (exp_q.size() != 0 || rsp_valid); t++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic lid;
        #1;
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_sum", int'(rsp_sum), 0);
        chk("rst_rsp_id_ovf", int'({rsp_id, rsp_ovf}), 0);
        chk("rst_readys", int'({req0_ready, req1_ready}), 2);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(1'b0, 8'd2, 8'd3, 8'd5, 1'b0);
        send(1'b1, 8'd200, 8'd100, 8'd44, 1'b1);
        send(1'b1, 8'd77, 8'd118, 8'd195, 1'b0);
        drain();

        // Contention: last grant was 1, so 0 wins first and grants alternate.
        rise_q.delete();
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{id: 1'b0, sum: 8'd15, ovf: 1'b0});
            exp_q.push_back('{id: 1'b1, sum: 8'd75, ovf: 1'b0});
        end
        r0a = 8'd7;  r0b = 8'd8;  r1a = 8'd17; r1b = 8'd58;
        r0v = 1'b1;  r1v = 1'b1;
        wait_accepts(4, lid);
        chk("contention_last_id", int'(lid), 1);
        r0v = 1'b0;  r1v = 1'b0;
        drain();
        chk("contention_rises", rise_q.size(), 4);
        for (int i = 0; i + 1 < rise_q.size(); i++) chk("op_spacing", rise_q[i+1] - rise_q[i], 4);

        // Backpressure with both requesters waiting.
        rsp_ready = 1'b0;
        exp_q.push_back('{id: 1'b0, sum: 8'd15, ovf: 1'b0});
        exp_q.push_back('{id: 1'b1, sum: 8'd75, ovf: 1'b0});
        r0v = 1'b1;  r1v = 1'b1;
        wait_accepts(1, lid);
        chk("bp_first_grant", int'(lid), 0);
        for (int t = 0; t < 10 && !rsp_valid; t++) @(negedge clk);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            #1;
            chk("bp_valid_held", int'(rsp_valid), 1);
            chk("bp_readys", int'({req0_ready, req1_ready}), 0);
        end
        rsp_ready = 1'b1;
        wait_accepts(1, lid);
        chk("bp_next_grant", int'(lid), 1);
        r0v = 1'b0;  r1v = 1'b0;
        drain();

        // Reset one cycle into ADD: nothing may come out of the discarded operation.
        r0v = 1'b1;  r0a = 8'd9;  r0b = 8'd9;
        wait_accepts(1, lid);
        r0v = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", int'(rsp_valid), 0);
        chk("midrst_rsp_sum", int'(rsp_sum), 0);
        chk("midrst_rsp_id_ovf", int'({rsp_id, rsp_ovf}), 0);
        chk("midrst_readys", int'({req0_ready, req1_ready}), 2);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("midrst_valid_low", int'(rsp_valid), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", int'(rsp_valid), 0);

        // Tie after reset goes to requester 0 again.
        exp_q.push_back('{id: 1'b0, sum: 8'd0, ovf: 1'b0});
        exp_q.push_back('{id: 1'b1, sum: 8'd11, ovf: 1'b0});
        r0a = 8'd0;  r0b = 8'd0;  r1a = 8'd5;  r1b = 8'd6;
        r0v = 1'b1;  r1v = 1'b1;
        wait_accepts(1, lid);
        chk("post_rst_tie_grant", int'(lid), 0);
        r0v = 1'b0;
        wait_accepts(1, lid);
        chk("post_rst_second_grant", int'(lid), 1);
        r1v = 1'b0;
        drain();

        // SETTLE_CYC=1 instance: response visible one edge after the accept.
        s1_r0v = 1'b1;  s1_r0a = 8'd255;  s1_r0b = 8'd1;
        #1;
        chk("s1_ready", int'(s1_req0_ready), 1);
        @(negedge clk);
        s1_r0v = 1'b0;
        chk("s1_valid_early", int'(s1_rsp_valid), 0);
        @(negedge clk);
        chk("s1_valid", int'(s1_rsp_valid), 1);
        chk("s1_sum", int'(s1_rsp_sum), 0);
        chk("s1_ovf", int'(s1_rsp_ovf), 1);
        chk("s1_id", int'(s1_rsp_id), 0);
        @(negedge clk);
        chk("s1_valid_cleared", int'(s1_rsp_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d compared", n_cmp);
        $fatal(1);
    end

endmodule
